// File: rtl/branch_sequencer.sv
// branch_sequencer: MicroEV20 program-counter sequencer with 2-bit branch
// prediction and an in-order queue of unresolved conditional branches.
module branch_sequencer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [1:0]  CTR_INIT = 2'b01
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [13:0]              instr_i,
    input  logic                     fetch_valid_i,
    input  logic                     resolve_valid_i,
    input  logic                     resolve_taken_i,
    output logic [10:0]              pc_o,
    output logic                     flush_o,
    output logic                     stall_o,
    output logic                     pred_taken_o,
    output logic [$clog2(DEPTH):0]   pending_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [10:0]   pc_q, pc_d;
    logic          flush_q, flush_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    ctr_q [4];
    logic [1:0]    ctr_d [4];

    // Queue storage: condition code, applied prediction, alternate pc
    logic [1:0]    q_cc_q   [DEPTH];
    logic          q_pred_q [DEPTH];
    logic [10:0]   q_alt_q  [DEPTH];

    logic          is_jump, is_cond, pred, do_pop, mispredict, advance, push;
    logic [1:0]    cc, head_cc;
    logic [10:0]   target, pc_inc;

    // Instruction decode, prediction and stall
    always_comb begin
        cc           = instr_i[12:11];
        target       = instr_i[10:0];
        pc_inc       = pc_q + 11'd1;
        is_jump      = (instr_i[13:11] == 3'b100);
        is_cond      = instr_i[13] && (cc != 2'b00);
        pred         = is_cond && ctr_q[cc][1];
        do_pop       = resolve_valid_i && (count_q != '0);
        head_cc      = q_cc_q[head_q];
        mispredict   = do_pop && (resolve_taken_i != q_pred_q[head_q]);
        // A same-cycle resolve frees a slot, so a full queue does not stall then
        stall_o      = is_cond && fetch_valid_i && (count_q == CW'(DEPTH)) && !do_pop;
        advance      = fetch_valid_i && !stall_o;
        push         = advance && is_cond && !mispredict;
        pred_taken_o = pred;
    end

    // Next-state: redirect on mispredict beats any fetch advance
    always_comb begin
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        flush_d = mispredict;
        for (int i = 0; i < 4; i++) begin
            ctr_d[i] = ctr_q[i];
        end

        if (do_pop) begin
            if (resolve_taken_i) begin
                if (ctr_q[head_cc] != 2'b11) ctr_d[head_cc] = ctr_q[head_cc] + 2'd1;
            end else begin
                if (ctr_q[head_cc] != 2'b00) ctr_d[head_cc] = ctr_q[head_cc] - 2'd1;
            end
        end

        if (mispredict) begin
            pc_d    = q_alt_q[head_q];
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (advance) begin
                if (is_jump || pred) pc_d = target;
                else                 pc_d = pc_inc;
            end
            if (do_pop) head_d = head_q + PW'(1);
            if (push)   tail_d = tail_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(do_pop);
        end
    end

    // Control state, asynchronously reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q    <= '0;
            flush_q <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < 4; i++) begin
                ctr_q[i] <= CTR_INIT;
            end
        end else begin
            pc_q    <= pc_d;
            flush_q <= flush_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < 4; i++) begin
                ctr_q[i] <= ctr_d[i];
            end
        end
    end

    // Queue entry write on push
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_cc_q[i]   <= 2'b00;
                q_pred_q[i] <= 1'b0;
                q_alt_q[i]  <= '0;
            end
        end else if (push) begin
            q_cc_q[tail_q]   <= cc;
            q_pred_q[tail_q] <= pred;
            q_alt_q[tail_q]  <= pred ? pc_inc : target;
        end
    end

    // Registered outputs
    always_comb begin
        pc_o      = pc_q;
        flush_o   = flush_q;
        pending_o = count_q;
    end

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: queue-based reference model plus
// directed scenarios with literal expectations.
module tb_branch_sequencer;

    localparam int DEPTH = 4;
    localparam logic [1:0] CTR_INIT = 2'b01;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] instr = '0;
    logic        fetch_valid = 1'b0;
    logic        resolve_valid = 1'b0;
    logic        resolve_taken = 1'b0;
    logic [10:0] pc;
    logic        flush, stall, pred_taken;
    logic [2:0]  pending;

    int n_tests = 0;
    int n_fail  = 0;

    branch_sequencer #(.DEPTH(DEPTH), .CTR_INIT(CTR_INIT)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .instr_i         (instr),
        .fetch_valid_i   (fetch_valid),
        .resolve_valid_i (resolve_valid),
        .resolve_taken_i (resolve_taken),
        .pc_o            (pc),
        .flush_o         (flush),
        .stall_o         (stall),
        .pred_taken_o    (pred_taken),
        .pending_o       (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int cc; bit pred; int alt; } ent_t;
    ent_t mq[$];
    int   m_pc;
    bit   m_flush;
    int   m_ctr[4];

    function automatic bit f_cond(input logic [13:0] i);
        return i[13] && (i[12:11] != 2'b00);
    endfunction

    function automatic bit f_jump(input logic [13:0] i);
        return i[13:11] == 3'b100;
    endfunction

    function automatic bit f_pred(input logic [13:0] i);
        return f_cond(i) && (m_ctr[i[12:11]] >= 2);
    endfunction

    function automatic bit f_stall(input logic [13:0] i);
        return f_cond(i) && fetch_valid && (mq.size() == DEPTH) && !resolve_valid;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = 0;
            m_flush = 0;
            mq.delete();
            for (int i = 0; i < 4; i++) m_ctr[i] = CTR_INIT;
        end else begin
            bit   p, st, mis;
            ent_t h;
            int   tgt, cc;
            p   = f_pred(instr);
            st  = f_stall(instr);
            tgt = instr[10:0];
            cc  = instr[12:11];
            mis = 0;
            if (resolve_valid && mq.size() > 0) begin
                h = mq.pop_front();
                if (resolve_taken) m_ctr[h.cc] = (m_ctr[h.cc] == 3) ? 3 : m_ctr[h.cc] + 1;
                else               m_ctr[h.cc] = (m_ctr[h.cc] == 0) ? 0 : m_ctr[h.cc] - 1;
                mis = (resolve_taken != h.pred);
            end
            m_flush = mis;
            if (mis) begin
                m_pc = h.alt;
                mq.delete();
            end else if (fetch_valid && !st) begin
                if (f_jump(instr)) begin
                    m_pc = tgt;
                end else if (f_cond(instr)) begin
                    mq.push_back('{cc: cc, pred: p, alt: p ? (m_pc + 1) % 2048 : tgt});
                    m_pc = p ? tgt : (m_pc + 1) % 2048;
                end else begin
                    m_pc = (m_pc + 1) % 2048;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("pc", pc, m_pc);
            chk("flush", flush, m_flush);
            chk("pending", pending, mq.size());
            chk("stall", stall, f_stall(instr));
            chk("pred_taken", pred_taken, f_pred(instr));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [13:0] i, input logic fv, input logic rv, input logic rt);
        instr = i;
        fetch_valid = fv;
        resolve_valid = rv;
        resolve_taken = rt;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [13:0] jmp(input int t);
        return {3'b100, 11'(t)};
    endfunction

    function automatic logic [13:0] cnd(input int c, input int t);
        return {1'b1, 2'(c), 11'(t)};
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("lit_reset_pc", pc, 0);
        chk("lit_reset_pending", pending, 0);
        chk("lit_reset_flush", flush, 0);

        // Sequential fetch
        repeat (3) drive(14'h0000, 1, 0, 0);
        chk("lit_seq_pc3", pc, 3);
        repeat (2) drive(14'h0000, 1, 0, 0);
        chk("lit_seq_pc5", pc, 5);

        // Unconditional jump
        drive(14'b100_00000101010, 1, 0, 0);
        chk("lit_jump_pc42", pc, 42);
        chk("lit_jump_pending", pending, 0);

        // Mispredicted conditional at pc=10
        drive(jmp(10), 1, 0, 0);
        drive(14'b101_00001100100, 1, 0, 0);
        chk("lit_cond_pc11", pc, 11);
        chk("lit_cond_pending1", pending, 1);
        drive(14'h0000, 0, 1, 1);
        chk("lit_mis_pc100", pc, 100);
        chk("lit_mis_flush", flush, 1);
        chk("lit_mis_pending0", pending, 0);
        drive(14'h0000, 0, 0, 0);
        chk("lit_flush_oneshot", flush, 0);

        // Same branch now predicted taken
        drive(jmp(10), 1, 0, 0);
        drive(14'b101_00001100100, 1, 0, 0);
        chk("lit_pred_taken_pc100", pc, 100);
        drive(14'h0000, 0, 1, 1);
        chk("lit_correct_noflush", flush, 0);

        // Fill queue, stall, then pop+push in one cycle
        repeat (4) drive(cnd(2, 200), 1, 0, 0);
        chk("lit_full_pending", pending, 4);
        instr = cnd(2, 200); fetch_valid = 1; resolve_valid = 0;
        @(negedge clk);
        chk("lit_stall_high", stall, 1);
        @(posedge clk); #1;
        chk("lit_stall_pc_hold", pc, 104);
        resolve_valid = 1; resolve_taken = 0;
        #1;
        chk("lit_stall_released", stall, 0);
        @(posedge clk); #1;
        chk("lit_poppush_pending", pending, 4);
        repeat (4) drive(14'h0000, 0, 1, 0);
        chk("lit_drained", pending, 0);

        // Counter saturation on cc=11
        repeat (6) begin
            drive(cnd(3, 300), 1, 0, 0);
            drive(14'h0000, 0, 1, 1);
        end
        repeat (5) begin
            drive(cnd(3, 300), 1, 0, 0);
            drive(14'h0000, 0, 1, 0);
        end
        instr = cnd(3, 300); fetch_valid = 0; resolve_valid = 0;
        #1;
        chk("lit_ctr11_sat_low", pred_taken, 0);

        // pc wrap
        drive(jmp(2047), 1, 0, 0);
        drive(14'h0000, 1, 0, 0);
        chk("lit_wrap_pc0", pc, 0);

        // Resolve with empty queue is ignored
        drive(14'h0000, 0, 1, 1);
        chk("lit_empty_resolve_pc", pc, 0);
        chk("lit_empty_resolve_flush", flush, 0);

        // Async reset with three pending
        repeat (3) drive(cnd(1, 500), 1, 0, 0);
        chk("lit_pending3", pending, 3);
        instr = '0; fetch_valid = 0;
        #2 rst = 1'b1;
        #1;
        chk("lit_async_pc", pc, 0);
        chk("lit_async_pending", pending, 0);
        @(posedge clk); #1 rst = 1'b0;
        instr = cnd(1, 500);
        #1;
        chk("lit_ctr_reinit", pred_taken, 0);

        // Async reset cancels a pending flush
        drive(cnd(1, 500), 1, 0, 0);
        drive(14'h0000, 0, 1, 1);
        chk("lit_flush_before_rst", flush, 1);
        #2 rst = 1'b1;
        #1;
        chk("lit_flush_cleared", flush, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) drive(14'h0000, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
